// File: rtl/cla_nibble_sub_if.sv
// Valid/ready operand and result bundle for cla_nibble_sub.
// Optional op field exists only when CLA_SUB_ADDMODE_EN is defined.
interface cla_nibble_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
`ifdef CLA_SUB_ADDMODE_EN
    logic             op;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

`ifdef CLA_SUB_ADDMODE_EN
    modport master (
        output in_valid, a, b, bin, op, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
    modport slave (
        input  in_valid, a, b, bin, op, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`endif
endinterface

// File: rtl/cla_nibble_sub.sv
// Multi-cycle subtractor: one 4-bit carry-lookahead slice, one nibble per cycle, LSB first.
// Define CLA_SUB_ADDMODE_EN to add an op field selecting add (1) or subtract (0).
module cla_nibble_sub #(
    parameter int unsigned WIDTH = 16  // multiple of 4, >= 8
) (
    input logic           clk,
    input logic           rst_n,
    cla_nibble_sub_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             c_q, c_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             add_mode;
    logic             start_add;

`ifdef CLA_SUB_ADDMODE_EN
    logic op_q, op_d;
    assign add_mode  = op_q;
    assign start_add = bus.op;
`else
    assign add_mode  = 1'b0;
    assign start_add = 1'b0;
`endif

    // Lookahead slice over the current nibble
    logic [3:0] nib_a, nib_b, g, p, sum;
    logic [4:0] cy;

    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = add_mode ? b_q[{idx_q, 2'b00} +: 4] : ~b_q[{idx_q, 2'b00} +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        cy[0] = c_q;
        cy[1] = g[0] | (p[0] & c_q);
        cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
        cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
        cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_q);
        sum   = p ^ cy[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        c_d     = c_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
`ifdef CLA_SUB_ADDMODE_EN
        op_d    = op_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    // Subtract runs as a + ~b + ~bin
                    c_d     = start_add ? bus.bin : ~bus.bin;
                    idx_d   = '0;
`ifdef CLA_SUB_ADDMODE_EN
                    op_d    = bus.op;
`endif
                    state_d = StCalc;
                end
            end
            StCalc: begin
                diff_d[{idx_q, 2'b00} +: 4] = sum;
                c_d   = cy[4];
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(NIB - 1)) begin
                    bout_d  = add_mode ? cy[4] : ~cy[4];
                    ovf_d   = cy[3] ^ cy[4];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef CLA_SUB_ADDMODE_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
`ifdef CLA_SUB_ADDMODE_EN
            op_q    <= op_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_nibble_sub.sv
// Directed bench for cla_nibble_sub with an arithmetic reference model and per-cycle compare.
module tb_cla_nibble_sub;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_nibble_sub_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_sub #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_diff = '0;
    logic        exp_bout = 1'b0;
    logic        exp_ovf  = 1'b0;
    logic        op_drv   = 1'b0;

`ifdef CLA_SUB_ADDMODE_EN
    assign bus.op = op_drv;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Unsigned result from 17-bit arithmetic, overflow from the signed range
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                  input logic op, output logic [15:0] d, output logic bo,
                                  output logic ov);
        logic [16:0] u;
        longint      sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            u = {1'b0, a} + {1'b0, b} + 17'(bin);
            r = sa + sb + longint'(bin);
        end else begin
            u = {1'b0, a} - {1'b0, b} - 17'(bin);
            r = sa - sb - longint'(bin);
        end
        d  = u[15:0];
        bo = u[16];
        ov = (r > 32767) || (r < -32768);
    endfunction

    // Compare process: whenever a result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready/valid exclusive", 32'(bus.in_ready & bus.out_valid), 0);
            if (bus.out_valid) begin
                check("cmp diff", 32'(bus.diff), 32'(exp_diff));
                check("cmp bout", 32'(bus.bout), 32'(exp_bout));
                check("cmp ovf", 32'(bus.ovf), 32'(exp_ovf));
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input logic op, input int hold, output logic [15:0] d,
                         output logic bo, output logic ov, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready before accept", 32'(bus.in_ready), 1);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        op_drv       = op;
        bus.in_valid = 1'b1;
        model(a, b, bin, op, exp_diff, exp_bout, exp_ovf);
        lat = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 20);
        check("out_valid rises", 32'(bus.out_valid), 1);
        d  = bus.diff;
        bo = bus.bout;
        ov = bus.ovf;
        for (int i = 0; i < hold; i++) begin
            // A competing request while busy must be ignored
            bus.in_valid = 1'b1;
            bus.a        = ~a;
            bus.b        = a;
            @(negedge clk);
            check("held out_valid", 32'(bus.out_valid), 1);
            check("held in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle after handshake valid", 32'(bus.out_valid), 0);
        check("idle after handshake ready", 32'(bus.in_ready), 1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #300000;
        $display("FAIL global timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        logic        bo, ov;
        int          lat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;

        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 1);
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset diff", 32'(bus.diff), 0);
        check("reset bout", 32'(bus.bout), 0);
        check("reset ovf", 32'(bus.ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h0005, 16'h0003, 1'b0, 1'b0, 0, d, bo, ov, lat);
        check("t1 diff", 32'(d), 32'h0002);
        check("t1 bout", 32'(bo), 0);
        check("t1 ovf", 32'(ov), 0);
        check("t1 latency", 32'(lat), 5);

        do_op(16'h0000, 16'h0001, 1'b0, 1'b0, 0, d, bo, ov, lat);
        check("t2 diff", 32'(d), 32'hFFFF);
        check("t2 bout", 32'(bo), 1);
        check("t2 ovf", 32'(ov), 0);

        do_op(16'h8000, 16'h0001, 1'b0, 1'b0, 1, d, bo, ov, lat);
        check("t3a diff", 32'(d), 32'h7FFF);
        check("t3a bout", 32'(bo), 0);
        check("t3a ovf", 32'(ov), 1);

        do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 0, d, bo, ov, lat);
        check("t3b diff", 32'(d), 32'h8000);
        check("t3b bout", 32'(bo), 1);
        check("t3b ovf", 32'(ov), 1);

        do_op(16'h1234, 16'h1234, 1'b1, 1'b0, 3, d, bo, ov, lat);
        check("t4 diff", 32'(d), 32'hFFFF);
        check("t4 bout", 32'(bo), 1);
        check("t4 ovf", 32'(ov), 0);

        // Reset during the second CALC cycle
        bus.a        = 16'hABCD;
        bus.b        = 16'h1111;
        bus.bin      = 1'b0;
        op_drv       = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5 rst out_valid", 32'(bus.out_valid), 0);
        check("t5 rst in_ready", 32'(bus.in_ready), 1);
        check("t5 rst diff", 32'(bus.diff), 0);
        check("t5 rst bout", 32'(bus.bout), 0);
        check("t5 rst ovf", 32'(bus.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h00F0, 16'h000F, 1'b0, 1'b0, 0, d, bo, ov, lat);
        check("t5 diff", 32'(d), 32'h00E1);
        check("t5 bout", 32'(bo), 0);

        vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 0};
        vecs[1] = '{16'h0000, 16'hFFFF, 1'b1, 1};
        vecs[2] = '{16'h8000, 16'h7FFF, 1'b0, 0};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 2};
        vecs[4] = '{16'h0F0F, 16'hF0F0, 1'b0, 0};
        vecs[5] = '{16'h1000, 16'h0FFF, 1'b1, 0};
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, vecs[i].hold, d, bo, ov, lat);
            check("table latency", 32'(lat), 5);
        end

`ifdef CLA_SUB_ADDMODE_EN
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, d, bo, ov, lat);
        check("t6a diff", 32'(d), 32'h0000);
        check("t6a bout", 32'(bo), 1);
        check("t6a ovf", 32'(ov), 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, d, bo, ov, lat);
        check("t6b diff", 32'(d), 32'h8000);
        check("t6b ovf", 32'(ov), 1);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b1, 1, d, bo, ov, lat);
        check("t6c diff", 32'(d), 32'h5556);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
